// File: rtl/turbo_output_serializer.sv
// Turbo encoder output stage: one pending frame buffer plus a shift engine that streams sys/par1/par2 MSB first.
// Define PUNCTURE_EN for rate 1/2 output: sys[i], then par1[i] for even k or par2[i] for odd k.
module turbo_output_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sys_in,
    input  logic [WIDTH-1:0] par1_in,
    input  logic [WIDTH-1:0] par2_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last,
    output logic             busy
);
    localparam int KW = $clog2(WIDTH);
    localparam logic [KW-1:0] K_MAX = KW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SYS = 2'd1, PAR1 = 2'd2, PAR2 = 2'd3} state_t;

    state_t           state_r, state_s;
    logic [KW-1:0]    k_r, k_s, idx_s;
    logic [WIDTH-1:0] sys_r, par1_r, par2_r, sys_s, par1_s, par2_s;
    logic             pend_full_r, pend_full_s;
    logic [WIDTH-1:0] pend_sys_r, pend_par1_r, pend_par2_r;
    logic [WIDTH-1:0] pend_sys_s, pend_par1_s, pend_par2_s;
    logic             out_valid_r, out_bit_r, out_last_r, busy_r;
    logic             bit_s, last_s;
    logic             handshake_s, finish_s, engine_free_s, in_fire_s;

    assign in_ready      = ~pend_full_r & ~reset;
    assign out_valid     = out_valid_r;
    assign out_bit       = out_bit_r;
    assign out_last      = out_last_r;
    assign busy          = busy_r;
    assign handshake_s   = out_valid_r & out_ready;
    assign finish_s      = handshake_s & out_last_r;
    assign engine_free_s = (state_r == IDLE) | finish_s;
    assign in_fire_s     = in_valid & in_ready;

    // Engine next state: frame routing at end of frame and per-bit FSM advance.
    always_comb begin
        state_s = state_r;
        k_s     = k_r;
        sys_s   = sys_r;
        par1_s  = par1_r;
        par2_s  = par2_r;
        if (finish_s) begin
            k_s = {KW{1'b0}};
            if (pend_full_r) begin
                state_s = SYS;
                sys_s   = pend_sys_r;
                par1_s  = pend_par1_r;
                par2_s  = pend_par2_r;
            end else if (in_fire_s) begin
                state_s = SYS;
                sys_s   = sys_in;
                par1_s  = par1_in;
                par2_s  = par2_in;
            end else begin
                state_s = IDLE;
            end
        end else if (state_r == IDLE) begin
            if (in_fire_s) begin
                state_s = SYS;
                k_s     = {KW{1'b0}};
                sys_s   = sys_in;
                par1_s  = par1_in;
                par2_s  = par2_in;
            end else begin
                state_s = IDLE;
            end
        end else if (handshake_s) begin
            case (state_r)
`ifdef PUNCTURE_EN
                SYS:  state_s = k_r[0] ? PAR2 : PAR1;
                PAR1, PAR2: begin
                    state_s = SYS;
                    k_s     = k_r + KW'(1'b1);
                end
`else
                SYS:  state_s = PAR1;
                PAR1: state_s = PAR2;
                PAR2: begin
                    state_s = SYS;
                    k_s     = k_r + KW'(1'b1);
                end
`endif
                default: state_s = IDLE;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Pending buffer: drained by a finishing engine, filled when the engine cannot take the frame.
    always_comb begin
        pend_full_s = pend_full_r;
        pend_sys_s  = pend_sys_r;
        pend_par1_s = pend_par1_r;
        pend_par2_s = pend_par2_r;
        if (finish_s && pend_full_r) begin
            pend_full_s = 1'b0;
        end else if (in_fire_s && !engine_free_s) begin
            pend_full_s = 1'b1;
            pend_sys_s  = sys_in;
            pend_par1_s = par1_in;
            pend_par2_s = par2_in;
        end else begin
            pend_full_s = pend_full_r;
        end
    end

    // Output bit and frame-end marker computed from next state so the outputs can be registered.
    always_comb begin
        idx_s = K_MAX - k_s;
        case (state_s)
            SYS:     bit_s = sys_s[idx_s];
            PAR1:    bit_s = par1_s[idx_s];
            PAR2:    bit_s = par2_s[idx_s];
            default: bit_s = 1'b0;
        endcase
`ifdef PUNCTURE_EN
        last_s = ((state_s == PAR1) || (state_s == PAR2)) && (k_s == K_MAX);
`else
        last_s = (state_s == PAR2) && (k_s == K_MAX);
`endif
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            k_r         <= {KW{1'b0}};
            sys_r       <= {WIDTH{1'b0}};
            par1_r      <= {WIDTH{1'b0}};
            par2_r      <= {WIDTH{1'b0}};
            pend_full_r <= 1'b0;
            pend_sys_r  <= {WIDTH{1'b0}};
            pend_par1_r <= {WIDTH{1'b0}};
            pend_par2_r <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            out_bit_r   <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            k_r         <= k_s;
            sys_r       <= sys_s;
            par1_r      <= par1_s;
            par2_r      <= par2_s;
            pend_full_r <= pend_full_s;
            pend_sys_r  <= pend_sys_s;
            pend_par1_r <= pend_par1_s;
            pend_par2_r <= pend_par2_s;
            out_valid_r <= (state_s != IDLE);
            out_bit_r   <= bit_s;
            out_last_r  <= last_s;
            busy_r      <= (state_s != IDLE) | pend_full_s;
        end
    end
endmodule

// File: tb/tb_turbo_output_serializer.sv
// Bench for turbo_output_serializer: bit-queue reference model checked every cycle, plus directed literal frames.
module tb_turbo_output_serializer;
    localparam int W = 8;
`ifdef PUNCTURE_EN
    localparam int FL = 2 * W;
    localparam logic [63:0] LIT_A = 64'h9D62;
    localparam logic [63:0] LIT_F = 64'hBBBB;
`else
    localparam int FL = 3 * W;
    localparam logic [63:0] LIT_A = 64'hA7B584;
    localparam logic [63:0] LIT_F = 64'hB6DB6D;
`endif

    logic clk = 1'b0;
    logic reset, in_valid, in_ready, out_valid, out_ready, out_bit, out_last, busy;
    logic [W-1:0] sys_in, par1_in, par2_in;

    int total = 0;
    int bad = 0;
    int inflight = 0;
    bit exp_q[$];
    bit last_q[$];
    bit cap_q[$];
    logic s_ov, s_ol, s_ob, s_busy, s_ir, s_acc;
    logic prev_hold = 1'b0, prev_bit = 1'b0, prev_last = 1'b0;

    turbo_output_serializer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .sys_in(sys_in), .par1_in(par1_in), .par2_in(par2_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected codeword of one frame, built straight from the bit-order rules.
    task automatic push_frame(input logic [W-1:0] s, input logic [W-1:0] p1, input logic [W-1:0] p2);
        for (int k = 0; k < W; k++) begin
            int i = W - 1 - k;
            exp_q.push_back(s[i]);
            last_q.push_back(1'b0);
`ifdef PUNCTURE_EN
            exp_q.push_back((k % 2 == 0) ? p1[i] : p2[i]);
            last_q.push_back(k == W - 1);
`else
            exp_q.push_back(p1[i]);
            last_q.push_back(1'b0);
            exp_q.push_back(p2[i]);
            last_q.push_back(k == W - 1);
`endif
        end
    endtask

    // One clock: check outputs at the negedge, advance the model for the coming edge, return 2ns after it.
    task automatic tick();
        @(negedge clk);
        s_ov = out_valid; s_ol = out_last; s_ob = out_bit; s_busy = busy; s_ir = in_ready;
        s_acc = in_valid & in_ready;
        check("out_valid", 64'(s_ov), 64'(exp_q.size() > 0));
        check("busy", 64'(s_busy), 64'(inflight > 0));
        check("in_ready", 64'(s_ir), 64'(!reset && inflight < 2));
        if (exp_q.size() > 0) begin
            check("out_bit", 64'(s_ob), 64'(exp_q[0]));
            check("out_last", 64'(s_ol), 64'(last_q[0]));
        end
        if (prev_hold) begin
            check("hold_bit", 64'(s_ob), 64'(prev_bit));
            check("hold_last", 64'(s_ol), 64'(prev_last));
        end
        prev_hold = s_ov & !out_ready & !reset;
        prev_bit = s_ob;
        prev_last = s_ol;
        if (reset) begin
            exp_q.delete();
            last_q.delete();
            inflight = 0;
        end else begin
            if (s_ov && out_ready) begin
                cap_q.push_back(s_ob);
                if (exp_q.size() > 0) begin
                    if (last_q[0]) inflight--;
                    void'(exp_q.pop_front());
                    void'(last_q.pop_front());
                end
            end
            if (s_acc) begin
                push_frame(sys_in, par1_in, par2_in);
                inflight++;
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [W-1:0] s, input logic [W-1:0] p1, input logic [W-1:0] p2);
        logic ok = 1'b0;
        in_valid = 1'b1; sys_in = s; par1_in = p1; par2_in = p2;
        for (int t = 0; t < 300 && !ok; t++) begin
            tick();
            ok = s_acc;
        end
        in_valid = 1'b0;
        check("send_accept", 64'(ok), 64'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int t = 0; t < 400 && inflight > 0; t++) tick();
        check("drain_empty", 64'(inflight), 64'd0);
    endtask

    function automatic logic [63:0] frame_at(input int start);
        logic [63:0] v = 64'd0;
        for (int j = 0; j < FL; j++)
            v = {v[62:0], ((start + j) < cap_q.size()) ? cap_q[start + j] : 1'b0};
        return v;
    endfunction

    initial begin
        int st;
        logic [3:0] bp = 4'b1001;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        sys_in = '0; par1_in = '0; par2_in = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("post_reset_in_ready", 64'(s_ir), 64'd1);
        check("post_reset_valid", 64'(s_ov), 64'd0);

        // single frame
        st = cap_q.size();
        send(8'hA5, 8'h3C, 8'hF0);
        tick();
        check("s1_latency", 64'(s_ov), 64'd1);
        drain();
        tick();
        check("s1_idle_valid", 64'(s_ov), 64'd0);
        check("s1_idle_busy", 64'(s_busy), 64'd0);
        check("s1_len", 64'(cap_q.size() - st), 64'(FL));
        check("s1_bits", frame_at(st), LIT_A);

        // back-to-back frames, third waits for space
        st = cap_q.size();
        send(8'hA5, 8'h3C, 8'hF0);
        send(8'hFF, 8'h00, 8'hFF);
        tick();
        check("s2_in_ready_low", 64'(s_ir), 64'd0);
        send(8'hA5, 8'h3C, 8'hF0);
        drain();
        check("s2_frame1", frame_at(st), LIT_A);
        check("s2_frame2", frame_at(st + FL), LIT_F);
        check("s2_frame3", frame_at(st + 2 * FL), LIT_A);

        // backpressure 1,0,0,1
        st = cap_q.size();
        send(8'hA5, 8'h3C, 8'hF0);
        for (int c = 0; c < 8 * FL && inflight > 0; c++) begin
            out_ready = bp[3 - (c % 4)];
            tick();
        end
        drain();
        check("s3_bits", frame_at(st), LIT_A);

        // reset mid-frame with pending full
        st = cap_q.size();
        send(8'hA5, 8'h3C, 8'hF0);
        send(8'hA5, 8'h3C, 8'hF0);
        for (int t = 0; t < 100 && (cap_q.size() - st) < 10; t++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("s4_valid", 64'(s_ov), 64'd0);
        check("s4_busy", 64'(s_busy), 64'd0);
        check("s4_in_ready", 64'(s_ir), 64'd1);
        st = cap_q.size();
        send(8'hFF, 8'h00, 8'hFF);
        drain();
        check("s4_bits", frame_at(st), LIT_F);

        // frame offered on the exact last-bit edge with pending empty
        st = cap_q.size();
        send(8'hA5, 8'h3C, 8'hF0);
        repeat (FL - 1) tick();
        in_valid = 1'b1; sys_in = 8'hFF; par1_in = 8'h00; par2_in = 8'hFF;
        tick();
        in_valid = 1'b0;
        check("s5_last", 64'(s_ol), 64'd1);
        check("s5_accept", 64'(s_acc), 64'd1);
        tick();
        check("s5_next_valid", 64'(s_ov), 64'd1);
        check("s5_next_busy", 64'(s_busy), 64'd1);
        drain();
        check("s5_frame1", frame_at(st), LIT_A);
        check("s5_frame2", frame_at(st + FL), LIT_F);

        // randomized traffic with occasional reset
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            sys_in = W'($urandom());
            par1_in = W'($urandom());
            par2_in = W'($urandom());
            out_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0;
        in_valid = 1'b0;
        drain();
        tick();
        check("rand_final_busy", 64'(s_busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
